// File: rtl/dmem_line_ctrl_if.sv
// dmem_line_if: line-transfer bus between the data cache and the line memory controller.
// The cache drives the request side (master); the memory controller answers (slave).
`timescale 1ns/1ps
`default_nettype none

interface dmem_line_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: off-chip data memory model serving 256-bit line fills and write-backs
// with a programmable access latency followed by an 8-beat word-serial transfer.
`timescale 1ns/1ps
`default_nettype none

module dmem_line_ctrl #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dmem_line_if.slave bus
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int LINE_W = ADDR_W - 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t              state;
  logic [7:0]          wait_cnt;
  logic [2:0]          beat;
  logic [LINE_W-1:0]   line_q;
  logic                wr_q;
  logic [255:0]        wdata_q;
  logic [255:0]        rdata_q;
  logic                ack_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   word_addr;
  logic [31:0]         mem [MEM_WORDS];

  assign word_addr = {line_q, beat};

  // Address bits above the storage range and the byte offset are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[4:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      beat     <= '0;
      line_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enable_i) begin
            line_q  <= bus.addr_i[ADDR_W+1:5];
            wr_q    <= bus.write_i;
            wdata_q <= bus.data_i;
            busy_q  <= 1'b1;
            beat    <= '0;
            if (LATENCY == 0) begin
              state <= S_XFER;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 8'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) begin
            state <= S_XFER;
            beat  <= '0;
          end
        end
        S_XFER: begin
          if (!wr_q) begin
            rdata_q[{beat, 5'd0} +: 32] <= mem[word_addr];
          end
          beat <= beat + 3'd1;
          if (beat == 3'd7) begin
            state <= S_ACK;
            ack_q <= 1'b1;
          end
        end
        S_ACK: begin
          state  <= S_IDLE;
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; an async reset mid-transfer forces IDLE so no further beat commits.
  always_ff @(posedge clk_i) begin
    if (state == S_XFER && wr_q) begin
      mem[word_addr] <= wdata_q[{beat, 5'd0} +: 32];
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.busy_o = busy_q;
  assign bus.data_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_line_ctrl.sv
// tb_dmem_line_ctrl: scoreboard bench for dmem_line_ctrl with LATENCY=10 and LATENCY=0 instances.
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_line_ctrl;

  typedef struct {
    int           cyc;
    bit           rd;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]   en;
  logic [1:0]   wr;
  logic [31:0]  addr [2];
  logic [255:0] wd [2];

  exp_t q0[$];
  exp_t q1[$];
  bit   prev0 = 1'b0;
  bit   prev1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_line_if bus10 ();
  dmem_line_if bus0 ();

  assign bus10.enable_i = en[0];
  assign bus10.write_i  = wr[0];
  assign bus10.addr_i   = addr[0];
  assign bus10.data_i   = wd[0];
  assign bus0.enable_i  = en[1];
  assign bus0.write_i   = wr[1];
  assign bus0.addr_i    = addr[1];
  assign bus0.data_i    = wd[1];

  dmem_line_ctrl #(.MEM_WORDS(4096), .LATENCY(10)) dut10 (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus10)
  );

  dmem_line_ctrl #(.MEM_WORDS(4096), .LATENCY(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus0)
  );

  function automatic int lat(input int d);
    return (d == 0) ? 10 : 0;
  endfunction

  function automatic logic [255:0] pat(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = base + step * 32'(k);
    return r;
  endfunction

  function automatic bit ackv(input int d);
    return (d == 0) ? bus10.ack_o : bus0.ack_o;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int c, input bit rd, input logic [255:0] dat);
    exp_t e;
    e.cyc = c; e.rd = rd; e.data = dat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor side of the scoreboard: every ack pops one expectation.
  task automatic mon_check(input int d, input bit prev, input logic [255:0] dout);
    exp_t e;
    bit   empty;
    checks++;
    if (prev) begin
      errors++;
      $display("FAIL ack_width dut%0d got=2+cycles exp=1cycle", d);
    end
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL unexpected_ack dut%0d cyc=%0d got=1 exp=0", d, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL ack_cycle dut%0d got=%0d exp=%0d", d, cyc, e.cyc);
    end
    if (e.rd) begin
      checks++;
      if (dout !== e.data) begin
        errors++;
        $display("FAIL read_data dut%0d got=%0h exp=%0h", d, dout, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus10.ack_o) mon_check(0, prev0, bus10.data_o);
    if (bus0.ack_o)  mon_check(1, prev1, bus0.data_o);
    prev0 = bus10.ack_o;
    prev1 = bus0.ack_o;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_ack(input int d, input int limit, input string name);
    do @(negedge clk); while (!ackv(d) && cyc < limit);
    checks++;
    if (!ackv(d)) begin
      errors++;
      $display("FAIL %s_timeout got=no_ack exp=ack_by_cyc_%0d", name, limit);
    end
  endtask

  task automatic req(input int d, input logic w, input logic [31:0] a,
                     input logic [255:0] wdat, input logic [255:0] expd, input string name);
    int cap;
    @(negedge clk);
    en[d] = 1'b1; wr[d] = w; addr[d] = a; wd[d] = wdat;
    cap = cyc + 1;
    push(d, cap + lat(d) + 8, !w, expd);
    wait_ack(d, cap + lat(d) + 30, name);
    en[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int           cap;
    logic [255:0] line_a;
    logic [255:0] abort_exp;
    line_a    = pat(32'h11111111, 32'h11111111);
    abort_exp = {160'h0, {3{32'hFFFFFFFF}}};

    rst_i = 1'b1;
    en = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    #1 rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dut10.mem[64 + i] <= 32'h0;
      dut10.mem[i]      <= 32'hDEAD0000 + 32'(i);
      dut0.mem[40 + i]  <= 32'hC0000000 + 32'(i);
    end

    // Requests raised while reset is held must not be accepted.
    en = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_busy10", 256'(bus10.busy_o), 256'd0);
    chk("rst_busy0",  256'(bus0.busy_o),  256'd0);
    chk("rst_ack10",  256'(bus10.ack_o),  256'd0);
    chk("rst_data10", bus10.data_o,       256'd0);
    en = 2'b00;
    @(negedge clk) rst_i = 1'b1;
    repeat (2) @(negedge clk);

    req(0, 1'b1, 32'h00000040, line_a, '0, "write_40");
    req(0, 1'b0, 32'h00000044, '0, line_a, "read_44");
    req(1, 1'b0, 32'h000000A0, '0, pat(32'hC0000000, 32'd1), "lat0_read");
    req(0, 1'b1, 32'h00004000, pat(32'hA5A5A5A5, 32'd0), '0, "wrap_write");
    req(0, 1'b0, 32'h00000000, '0, pat(32'hA5A5A5A5, 32'd0), "wrap_read");

    // Abort a write after beat 2 with an asynchronous reset pulse.
    @(negedge clk);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h00000100; wd[0] = {8{32'hFFFFFFFF}};
    cap = cyc + 1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_cyc(cap + 13);
    chk("abort_busy_before", 256'(bus10.busy_o), 256'd1);
    rst_i = 1'b0;
    #1;
    chk("abort_ack",  256'(bus10.ack_o),  256'd0);
    chk("abort_busy", 256'(bus10.busy_o), 256'd0);
    chk("abort_data", bus10.data_o,       256'd0);
    #1 rst_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort_mem%0d", i), 256'(dut10.mem[64 + i]),
          256'(abort_exp[32*i +: 32]));
    end
    repeat (25) @(negedge clk);
    chk("abort_idle", 256'(bus10.busy_o), 256'd0);
    req(0, 1'b0, 32'h00000100, '0, abort_exp, "after_abort_read");

    // Held enable: back-to-back capture; write_i and data_i changes mid-flight are ignored.
    @(negedge clk);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h00000180; wd[0] = pat(32'h01020304, 32'h10101010);
    cap = cyc + 1;
    push(0, cap + 18, 1'b0, '0);
    push(0, cap + 38, 1'b1, pat(32'h01020304, 32'h10101010));
    wait_cyc(cap + 12);
    wr[0] = 1'b0;
    wd[0] = '0;
    wait_cyc(cap + 20);
    chk("held_busy_recapture", 256'(bus10.busy_o), 256'd1);
    en[0] = 1'b0;
    wait_cyc(cap + 41);
    chk("held_drain", 256'(q0.size()), 256'd0);
    chk("final_drain0", 256'(q1.size()), 256'd0);
    chk("final_idle", 256'(bus10.busy_o), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
